// File: rtl/nvram_pkg.sv
// rtl/nvram_pkg.sv - shared state encoding and default widths for the NVRAM shadow block
package nvram_pkg;
   localparam int DEF_DATA_W = 4;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STORE  = 2'd1,
      RECALL = 2'd2
   } nvram_state_t;
endpackage

// File: rtl/nvram_array.sv
// rtl/nvram_array.sv - single-port word array, synchronous write, asynchronous read
module nvram_array
   import nvram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   // No reset: contents must survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/nvram_shadow.sv
// rtl/nvram_shadow.sv - working RAM with shadow store, edge-triggered store/recall copy engine
// Optional power-up recall after reset: define NVRAM_AUTO_RECALL_EN.
module nvram_shadow
   import nvram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] i,
   output logic [DATA_W-1:0] o,
   input  logic              ce_n,
   input  logic              rw_n,
   input  logic              recall_n,
   input  logic              store_n,
   output logic              busy,
   output logic              done
);
   localparam logic [ADDR_W-1:0] CNT_LAST = '1;

   nvram_state_t      state, state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic              store_q, recall_q;
   logic              store_edge, recall_edge, cnt_last, auto_req;
   logic              is_idle;

   logic              ram_we, sh_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata, sh_rdata;

   assign is_idle     = (state == IDLE);
   assign store_edge  = store_q & ~store_n;
   assign recall_edge = recall_q & ~recall_n;
   assign cnt_last    = (cnt == CNT_LAST);
   assign busy        = ~is_idle;

`ifdef NVRAM_AUTO_RECALL_EN
   logic auto_pend;

   // Armed by reset, consumed by the first idle cycle afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         auto_pend <= 1'b1;
      end else if (is_idle) begin
         auto_pend <= 1'b0;
      end
   end

   assign auto_req = auto_pend;
`else
   assign auto_req = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (recall_edge || auto_req) begin
               state_nxt = RECALL;
            end else if (store_edge) begin
               state_nxt = STORE;
            end
         end
         STORE, RECALL: begin
            if (cnt_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         store_q  <= 1'b1;
         recall_q <= 1'b1;
         done     <= 1'b0;
         o        <= '0;
      end else begin
         state    <= state_nxt;
         store_q  <= store_n;
         recall_q <= recall_n;
         done     <= ~is_idle & cnt_last;
         // Counter idles at zero and wraps to zero after the last word.
         cnt      <= is_idle ? '0 : cnt + ADDR_W'(1);
         if (is_idle) begin
            o <= ram_rdata;
         end
      end
   end

   // Writes are gated by reset so an abort leaves the in-flight word untouched.
   assign ram_addr  = is_idle ? a : cnt;
   assign ram_wdata = is_idle ? i : sh_rdata;
   assign ram_we    = ~reset & (is_idle ? (~ce_n & ~rw_n) : (state == RECALL));
   assign sh_we     = ~reset & (state == STORE);

   nvram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   nvram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_shadow (
      .clk   (clk),
      .we    (sh_we),
      .addr  (cnt),
      .wdata (ram_rdata),
      .rdata (sh_rdata)
   );
endmodule

// File: tb/tb_nvram_shadow.sv
// tb/tb_nvram_shadow.sv - scoreboard bench for nvram_shadow against an array-level reference model
module tb_nvram_shadow;
   localparam int DW    = 4;
   localparam int AW    = 8;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] a = '0;
   logic [DW-1:0] i_d = '0;
   logic [DW-1:0] o;
   logic          ce_n = 1'b1, rw_n = 1'b1, recall_n = 1'b1, store_n = 1'b1;
   logic          busy, done;

   nvram_shadow #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .a        (a),
      .i        (i_d),
      .o        (o),
      .ce_n     (ce_n),
      .rw_n     (rw_n),
      .recall_n (recall_n),
      .store_n  (store_n),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int            n_chk = 0, n_fail = 0;
   logic [DW-1:0] ram_m [DEPTH];
   logic [DW-1:0] sh_m  [DEPTH];
   logic [DW-1:0] exp_rd [$];
   logic [AW-1:0] exp_rd_a [$];
   int            exp_ops [$];
   logic          rd_issue = 1'b0, rd_vld = 1'b0;

   always @(posedge clk) rd_vld <= rd_issue;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: pops read data and operation lengths as the DUT presents them.
   int   busy_cnt = 0, cur_exp = 0;
   bit   active = 0;
   logic busy_prev = 1'b0, done_prev = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         active    = 0;
         busy_cnt  = 0;
         busy_prev = 1'b0;
         done_prev = 1'b0;
      end else begin
         if (rd_vld) begin
            if (exp_rd.size() == 0) begin
               check("read_underflow", 1, 0);
            end else begin
               logic [DW-1:0] ed;
               logic [AW-1:0] ea;
               ed = exp_rd.pop_front();
               ea = exp_rd_a.pop_front();
               check($sformatf("read[%02h]", ea), 32'(o), 32'(ed));
            end
         end
         if (busy && !busy_prev) begin
            if (exp_ops.size() == 0) begin
               check("unexpected_op", 1, 0);
            end else begin
               cur_exp  = exp_ops.pop_front();
               active   = 1;
               busy_cnt = 0;
            end
         end
         if (busy) busy_cnt++;
         if (done) begin
            if (!active) begin
               check("spurious_done", 1, 0);
            end else begin
               check("busy_cycles", busy_cnt, cur_exp);
               check("busy_low_at_done", 32'(busy), 0);
            end
            if (done_prev) check("done_one_cycle", 1, 0);
            active = 0;
         end
         busy_prev = busy;
         done_prev = done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input bit eff, input bit chk);
      a = ad; i_d = d; ce_n = 1'b0; rw_n = 1'b0;
      if (chk) begin
         exp_rd.push_back(ram_m[ad]);
         exp_rd_a.push_back(ad);
         rd_issue = 1'b1;
      end
      if (eff) ram_m[ad] = d;
      tick();
      ce_n = 1'b1; rw_n = 1'b1; rd_issue = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] ad);
      a = ad; rw_n = 1'b1; ce_n = 1'($urandom_range(0, 1));
      exp_rd.push_back(ram_m[ad]);
      exp_rd_a.push_back(ad);
      rd_issue = 1'b1;
      tick();
      rd_issue = 1'b0; ce_n = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 600) begin
         tick();
         n++;
      end
      check({name, "_done_seen"}, 32'(done), 1);
      tick();
   endtask

   task automatic model_store();
      exp_ops.push_back(DEPTH);
      for (int k = 0; k < DEPTH; k++) sh_m[k] = ram_m[k];
   endtask

   task automatic model_recall();
      exp_ops.push_back(DEPTH);
      for (int k = 0; k < DEPTH; k++) ram_m[k] = sh_m[k];
   endtask

   initial begin
      logic [AW-1:0] ra;
      bit            skip40;

      tick();
      tick();
      check("reset_o", 32'(o), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      reset = 1'b0;
`ifdef NVRAM_AUTO_RECALL_EN
      exp_ops.push_back(DEPTH);
      wait_done("powerup_recall");
`endif

      wr(8'h10, 4'hA, 1, 0);
      rd(8'h10);

      for (int k = 0; k < DEPTH; k++) wr(AW'(k), DW'(k), 1, 0);
      for (int n = 0; n < 40; n++) begin
         ra = AW'($urandom);
         if ($urandom_range(0, 1) == 1) wr(ra, DW'($urandom), 1, 1'($urandom_range(0, 1)));
         else rd(ra);
      end
      for (int k = 0; k < DEPTH; k++) wr(AW'(k), DW'(k), 1, 0);

      // Store with an ignored write and a dropped recall request mid-copy.
      model_store();
      store_n = 1'b0;
      tick();
      store_n = 1'b1;
      repeat (5) tick();
      wr(8'h03, 4'hF, 0, 0);
      repeat (3) tick();
      recall_n = 1'b0;
      tick();
      recall_n = 1'b1;
      wait_done("store");
      rd(8'h03);

      for (int k = 0; k < DEPTH; k++) wr(AW'(k), '0, 1, 0);
      rd(8'h5A);
      model_recall();
      recall_n = 1'b0;
      tick();
      recall_n = 1'b1;
      wait_done("recall");
      rd(8'h5A);
      rd(8'h00);
      rd(8'hFF);
      for (int n = 0; n < 12; n++) rd(AW'($urandom));

      // Simultaneous edges: recall must win and no store may follow.
      for (int n = 0; n < 32; n++) wr(AW'($urandom), DW'($urandom), 1, 0);
      model_recall();
      store_n = 1'b0; recall_n = 1'b0;
      tick();
      store_n = 1'b1; recall_n = 1'b1;
      wait_done("both_edges");
      for (int n = 0; n < 24; n++) rd(AW'($urandom));
      repeat (300) tick();
      check("no_store_after_recall", 32'(busy), 0);

      // Abort a recall with reset at cnt=0x40.
      for (int k = 0; k < DEPTH; k++) wr(AW'(k), DW'(~k), 1, 0);
      exp_ops.push_back(DEPTH);
      recall_n = 1'b0;
      tick();
      recall_n = 1'b1;
      repeat (64) tick();
      reset = 1'b1;
      tick();
      check("abort_busy", 32'(busy), 0);
      check("abort_o", 32'(o), 0);
      check("abort_done", 32'(done), 0);
      for (int k = 0; k < 'h40; k++) ram_m[k] = sh_m[k];
      tick();
      reset = 1'b0;
      skip40 = 1;
`ifdef NVRAM_AUTO_RECALL_EN
      model_recall();
      wait_done("auto_recall");
      skip40 = 0;
`endif
      rd(8'h00);
      rd(8'h3F);
      rd(8'h41);
      rd(8'hFF);
      for (int n = 0; n < 24; n++) begin
         ra = AW'($urandom);
         if (!(skip40 && ra == 8'h40)) rd(ra);
      end

      repeat (3) tick();
      check("reads_drained", exp_rd.size(), 0);
      check("ops_drained", exp_ops.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end
endmodule
